// File: rtl/median_window_scheduler.sv
// Walks every interior 3x3 window of a frame buffer and streams its nine taps,
// in raster order, to the median datapath, with a one-cycle gap between windows.
module median_window_scheduler #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic        rdEn,
    output logic [7:0]  rdAddrX,
    output logic [7:0]  rdAddrY,
    input  logic        rdData,
    output logic        dataValid,
    output logic        dataOut,
    output logic [7:0]  xAddressOut,
    output logic [7:0]  yAddressOut,
    output logic [15:0] windowCount
);

    typedef enum logic [2:0] {IDLE, FETCH, GAP, WAIT, DONE} state_t;

    localparam logic [7:0] LAST_X = 8'(IMG_W - 2);
    localparam logic [7:0] LAST_Y = 8'(IMG_H - 2);

    state_t      state, stateNext;
    logic [7:0]  cx, cy;
    logic [3:0]  k;
    logic        lastWin;
    logic        launch;
    logic        doneQ;
    logic        vld_p1;
    logic [7:0]  xAddr_p1, yAddr_p1;

    function automatic logic [1:0] tapCol(input logic [3:0] tap);
        case (tap)
            4'd1, 4'd4, 4'd7: tapCol = 2'd1;
            4'd2, 4'd5, 4'd8: tapCol = 2'd2;
            default:          tapCol = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] tapRow(input logic [3:0] tap);
        if (tap >= 4'd6)      tapRow = 2'd2;
        else if (tap >= 4'd3) tapRow = 2'd1;
        else                  tapRow = 2'd0;
    endfunction

    function automatic logic [15:0] satInc(input logic [15:0] v);
        satInc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign lastWin = (cx == LAST_X) && (cy == LAST_Y);
    // A start coinciding with the done pulse must not relaunch the pass.
    assign launch  = (state == IDLE) && start && !doneQ;

    always_comb begin
        stateNext = state;
        rdEn      = 1'b0;
        rdAddrX   = 8'd0;
        rdAddrY   = 8'd0;
        case (state)
            IDLE:  if (launch) stateNext = FETCH;
            FETCH: begin
                rdEn    = 1'b1;
                rdAddrX = cx - 8'd1 + {6'd0, tapCol(k)};
                rdAddrY = cy - 8'd1 + {6'd0, tapRow(k)};
                if (k == 4'd8) stateNext = GAP;
            end
            GAP: begin
                if (lastWin)   stateNext = DONE;
                else if (hold) stateNext = WAIT;
                else           stateNext = FETCH;
            end
            WAIT:  if (!hold) stateNext = FETCH;
            DONE:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = doneQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cx          <= 8'd0;
            cy          <= 8'd0;
            k           <= 4'd0;
            windowCount <= 16'd0;
            doneQ       <= 1'b0;
        end else begin
            state <= stateNext;
            doneQ <= (state == DONE);
            if (launch) begin
                cx          <= 8'd1;
                cy          <= 8'd1;
                k           <= 4'd0;
                windowCount <= 16'd0;
            end
            if (state == FETCH) k <= (k == 4'd8) ? 4'd0 : k + 4'd1;
            if (state == GAP) begin
                windowCount <= satInc(windowCount);
                if (cx < LAST_X) begin
                    cx <= cx + 8'd1;
                end else begin
                    cx <= 8'd1;
                    cy <= cy + 8'd1;
                end
            end
        end
    end

    // Stage p1: read strobe and address aligned with the returning pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            xAddr_p1 <= 8'd0;
            yAddr_p1 <= 8'd0;
        end else begin
            vld_p1   <= rdEn;
            xAddr_p1 <= rdAddrX;
            yAddr_p1 <= rdAddrY;
        end
    end

    assign dataValid   = vld_p1;
    assign xAddressOut = xAddr_p1;
    assign yAddressOut = yAddr_p1;
    assign dataOut     = rdData;

endmodule

// File: doc/median_window_scheduler.md
Name: median_window_scheduler

Overview:
- Sequences a binary-image median filter pass: walks every interior 3x3 window of a frame buffer, issues 9 pixel reads per window and streams them with a contiguous valid strobe to the downstream median datapath.
- Sits between the frame-buffer read port and the median process.
- Inserts exactly one invalid cycle between windows so the datapath's pixel counter restarts.
- Supports backpressure between windows, and a start/busy/done handshake to the top-level controller.

Parameters:
- IMG_W, 128, image width in pixels (3..256)
- IMG_H, 128, image height in pixels (3..256)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begins a frame pass (ignored while busy)
- hold  in  1  downstream stall, sampled only at window boundaries
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last window's 9th pixel
- rdEn  out  1  frame-buffer read enable
- rdAddrX  out  8  read column
- rdAddrY  out  8  read row
- rdData  in  1  read data, valid exactly 1 cycle after rdEn
- dataValid  out  1  pixel strobe to the median datapath
- dataOut  out  1  pixel to the median datapath, combinational from rdData
- xAddressOut  out  8  column of the pixel on dataOut
- yAddressOut  out  8  row of the pixel on dataOut
- windowCount  out  16  windows issued this pass; cleared on start

Behaviour:
- Reset (reset=0, async): state IDLE; busy, done, rdEn, dataValid = 0; rdAddrX/Y, xAddressOut, yAddressOut, windowCount = 0.
- Registers: center (cx, cy); tap index k (0..8).
- States and transitions:
  - IDLE: on start, set cx=1, cy=1, k=0, windowCount=0, busy=1 -> FETCH.
  - FETCH: rdEn=1; rdAddrX = cx-1+(k mod 3); rdAddrY = cy-1+(k div 3), so taps are raster order top-left to bottom-right; k increments each cycle; k==8 -> GAP.
  - GAP (1 cycle): rdEn=0; windowCount++; advance center.
    - cx < IMG_W-2: cx++.
    - otherwise cx=1, cy++.
    - If the window just fetched had cx==IMG_W-2 and cy==IMG_H-2 -> DONE.
    - Else if hold=1 -> WAIT.
    - Else FETCH with k=0.
  - WAIT: rdEn=0; hold=0 -> FETCH with k=0.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Alignment:
  - dataValid = rdEn registered 1 cycle.
  - xAddressOut/yAddressOut = rdAddrX/Y registered 1 cycle.
  - dataOut = rdData.
  - Result: dataValid is high for exactly 9 consecutive cycles per window (FETCH k=1..8 plus GAP).
  - dataValid is low for at least 1 cycle before the next window (the first FETCH cycle, or WAIT cycles).
- hold is ignored during FETCH; a window is never split.
- Throughput: 10 cycles per window with hold=0. Full pass = (IMG_W-2)*(IMG_H-2)*10 + 2 cycles from start to done.
- Read addresses stay within 0..IMG_W-1 and 0..IMG_H-1; border pixels are read but never centered.
- start while busy has no effect; start in the same cycle as done is ignored.
- Async reset mid-pass aborts immediately to IDLE with all outputs at reset values; no done pulse.
- windowCount saturates at 16'hFFFF; unreachable at the maximum 256x256.

Test Plan:
- Reset then start, IMG_W=IMG_H=4 -> 4 windows; first reads (0,0),(1,0),(2,0),(0,1)...(2,2); windowCount=4; done exactly 42 cycles after start; busy low after done.
- Any frame -> every dataValid burst is exactly 9 cycles, separated by ≥1 low cycle; xAddressOut/yAddressOut match the rdAddr of the previous cycle.
- Raise hold during the 3rd window's FETCH for 5 cycles -> the window completes all 9 pixels; dataValid low for 5 cycles after GAP; the next window starts the cycle after hold falls.
- Frame buffer all ones, 5x5, fed into the median datapath -> 9 writes, each with dataOut=1; all zeros -> 9 windows, each with dataOut=0.
- Pulse start during busy -> no restart; windowCount continues monotonically.
- Assert reset low during the 2nd window's FETCH k=4 -> rdEn, dataValid, busy = 0 immediately; no done; a new start runs a full pass from (1,1).
